// File: rtl/fir_stim_pkg.sv
// fir_stim_pkg
//   Shared types and constants for the FIR stimulus generator.
//   - mode_e  : sequence selector latched on an accepted start
//   - state_e : sequencer states
//   - amplitude constants for the impulse, step and three-tone sequences
//   - tone_term() : signed contribution of one square-wave tone
package fir_stim_pkg;

  typedef enum logic [1:0] {
    MODE_TONE    = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_STEP    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int IMPULSE_AMP = 32'sd10000;
  localparam int STEP_AMP    = 32'sd800;
  localparam int TONE_AMP0   = 32'sd1000;
  localparam int TONE_AMP1   = 32'sd100;
  localparam int TONE_AMP2   = 32'sd100;

  // neg=1 selects the negative half-cycle of the square wave.
  function automatic int tone_term(input logic neg, input int amp);
    int val;
    if (neg) begin
      val = -amp;
    end else begin
      val = amp;
    end
    return val;
  endfunction

endpackage

// File: rtl/fir_stim_gen_square_osc.sv
// square_osc
//   Square-wave phase tracker for one tone. The internal phase (count_r,
//   sign_r) describes the sample currently on the generator output; it steps
//   once per accepted sample and flips sign every HALF samples.
//   Ports:
//     clk     - rising-edge clock
//     reset   - asynchronous active-low reset (count 0, sign +)
//     clear   - restart the phase at sample 0 (count 0, sign +)
//     advance - one sample was accepted downstream
//     sign    - sign of the FOLLOWING sample (1 = negative half-cycle).
//               The generator preloads its output register with the next
//               sample on the same edge the phase steps, so it needs this
//               one-sample lookahead rather than the current sign.
module square_osc #(
  parameter int HALF = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic sign
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] count_r;
  logic          sign_r;
  logic          wrap_s;

  // The current half-cycle ends after this sample.
  assign wrap_s = (count_r == CW'(HALF - 1));

  // Phase register: restart on clear, step on advance, flip sign on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
      sign_r  <= 1'b0;
    end else if (clear) begin
      count_r <= {CW{1'b0}};
      sign_r  <= 1'b0;
    end else if (advance) begin
      if (wrap_s) begin
        count_r <= {CW{1'b0}};
        sign_r  <= ~sign_r;
      end else begin
        count_r <= count_r + 1'b1;
      end
    end else begin
      count_r <= count_r;
      sign_r  <= sign_r;
    end
  end

  // Lookahead sign for the next sample index.
  assign sign = sign_r ^ wrap_s;

endmodule

// File: rtl/fir_stim_gen.sv
// fir_stim_gen
//   Test-stimulus source for a FIR filter input. On an accepted start it
//   emits 'length' samples of the selected sequence (three-tone square mix,
//   impulse, step or all-zero) under a valid/ready handshake, then pulses
//   done for one cycle.
//   Ports:
//     clk          - rising-edge clock
//     reset        - asynchronous active-low reset
//     start        - begin a sequence (only honoured while idle)
//     mode         - sequence select, latched with start
//     length       - number of samples, latched with start
//     sample_ready - downstream accepts the current sample
//     sample_valid - sample carries a valid value (registered)
//     sample       - signed sample value (registered)
//     busy         - sequence in progress (registered)
//     done         - one-cycle end-of-sequence pulse (registered)
module fir_stim_gen
  import fir_stim_pkg::*;
#(
  parameter int width      = 16,
  parameter int TONE_HALF0 = 100,
  parameter int TONE_HALF1 = 5,
  parameter int TONE_HALF2 = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [15:0]             length,
  input  logic                    sample_ready,
  output logic                    sample_valid,
  output logic signed [width-1:0] sample,
  output logic                    busy,
  output logic                    done
);

  // Two guard bits keep the sum of all terms from wrapping before saturation.
  localparam int SW = width + 2;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (width - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

  state_e                   state_r;
  mode_e                    mode_r;
  logic [15:0]              len_r;
  logic [15:0]              n_r;
  logic                     sample_valid_r;
  logic                     busy_r;
  logic                     done_r;
  logic signed [width-1:0]  sample_r;

  logic                     start_acc_s;
  logic                     xfer_s;
  logic                     last_s;
  logic                     nsign0_s;
  logic                     nsign1_s;
  logic                     nsign2_s;
  logic signed [width-1:0]  first_sample_s;
  logic signed [width-1:0]  next_sample_s;

  // Sample value for index idx given the tone signs that apply to it.
  function automatic logic signed [width-1:0] calc_sample(
    input mode_e       m,
    input logic [15:0] idx,
    input logic        s0,
    input logic        s1,
    input logic        s2
  );
    logic signed [SW-1:0]    sum;
    logic signed [width-1:0] res;
    case (m)
      MODE_TONE: begin
        sum = SW'(tone_term(s0, TONE_AMP0)) + SW'(tone_term(s1, TONE_AMP1))
            + SW'(tone_term(s2, TONE_AMP2));
      end
      MODE_IMPULSE: begin
        if (idx == 16'd0) begin
          sum = SW'(IMPULSE_AMP);
        end else begin
          sum = {SW{1'b0}};
        end
      end
      MODE_STEP: begin
        sum = SW'(STEP_AMP);
      end
      default: begin
        sum = {SW{1'b0}};
      end
    endcase
    if (sum > SAT_MAX) begin
      res = SAT_MAX[width-1:0];
    end else if (sum < SAT_MIN) begin
      res = SAT_MIN[width-1:0];
    end else begin
      res = sum[width-1:0];
    end
    return res;
  endfunction

  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign xfer_s      = sample_valid_r && sample_ready;
  assign last_s      = (n_r == (len_r - 16'd1));

  square_osc #(.HALF(TONE_HALF0)) u_osc0 (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc_s),
    .advance (xfer_s),
    .sign    (nsign0_s)
  );

  square_osc #(.HALF(TONE_HALF1)) u_osc1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc_s),
    .advance (xfer_s),
    .sign    (nsign1_s)
  );

  square_osc #(.HALF(TONE_HALF2)) u_osc2 (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_acc_s),
    .advance (xfer_s),
    .sign    (nsign2_s)
  );

  // Candidate values: index 0 of a fresh sequence (all tones positive), and
  // the index after the one being transferred now.
  always_comb begin
    first_sample_s = calc_sample(mode_e'(mode), 16'd0, 1'b0, 1'b0, 1'b0);
    next_sample_s  = calc_sample(mode_r, n_r + 16'd1, nsign0_s, nsign1_s, nsign2_s);
  end

  // Sequencer with registered handshake, status and sample outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      mode_r         <= MODE_TONE;
      len_r          <= 16'd0;
      n_r            <= 16'd0;
      sample_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      sample_r       <= {width{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mode_r <= mode_e'(mode);
            len_r  <= length;
            n_r    <= 16'd0;
            if (length != 16'd0) begin
              state_r        <= ST_RUN;
              sample_valid_r <= 1'b1;
              busy_r         <= 1'b1;
              sample_r       <= first_sample_s;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Without a transfer everything holds, so a stalled sample is
          // neither dropped nor repeated.
          if (xfer_s) begin
            if (last_s) begin
              state_r        <= ST_DONE;
              sample_valid_r <= 1'b0;
              busy_r         <= 1'b0;
              done_r         <= 1'b1;
              sample_r       <= {width{1'b0}};
            end else begin
              n_r      <= n_r + 16'd1;
              sample_r <= next_sample_s;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          sample_valid_r <= 1'b0;
          busy_r         <= 1'b0;
          done_r         <= 1'b0;
          sample_r       <= {width{1'b0}};
        end
      endcase
    end
  end

  assign sample_valid = sample_valid_r;
  assign sample       = sample_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen
//   Directed bench for fir_stim_gen. A sequence-level model (index of the
//   pending sample, latched mode/length) predicts valid/busy/done/sample on
//   every cycle; directed runs add hand-computed literal expectations.
module tb_fir_stim_gen;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         mode;
  logic [15:0]        length;
  logic               sample_ready;
  logic               sample_valid;
  logic signed [15:0] sample;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_errs   = 0;

  int xfer_cnt = 0;
  int done_cnt = 0;
  int cap [256];

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_idx  = 0;
  int          m_len  = 0;
  int          m_mode = 0;

  fir_stim_gen dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .length       (length),
    .sample_ready (sample_ready),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sq(input int n, input int half);
    return (((n / half) % 2) == 0) ? 1 : -1;
  endfunction

  function automatic int exp_sample(input int m, input int n);
    int v;
    case (m)
      0:       v = sq(n, 100) * 1000 + sq(n, 5) * 100 + sq(n, 12) * 100;
      1:       v = (n == 0) ? 10000 : 0;
      2:       v = 800;
      default: v = 0;
    endcase
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Sequence-level reference: which sample index is pending, if any.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (sample_ready) begin
        if (m_idx == m_len - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end else if (start) begin
      m_mode <= int'(mode);
      m_len  <= int'(length);
      m_idx  <= 0;
      if (length == 16'd0) m_done <= 1'b1;
      else                 m_busy <= 1'b1;
    end
  end

  // Observed transfers and done pulses.
  always @(posedge clk) begin
    if (reset) begin
      if (sample_valid && sample_ready) begin
        cap[xfer_cnt % 256] <= int'(sample);
        xfer_cnt <= xfer_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    chk("valid", int'(sample_valid), int'(m_busy));
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("sample", int'(sample), m_busy ? exp_sample(m_mode, m_idx) : 0);
  end

  // rpat: 0 ready always, 1 toggle 1/0, 2 random. extra_at: loop cycle with
  // a spurious start carrying different mode/length (-1 for none).
  task automatic run_seq(input logic [1:0] m, input int len, input int rpat,
                         input int extra_at, output int nx, output int nd,
                         output int base);
    int d0;
    bit seen;
    base = xfer_cnt;
    d0   = done_cnt;
    @(negedge clk); #1;
    mode = m; length = len[15:0]; start = 1'b1; sample_ready = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; mode = ~m; length = 16'd3;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      case (rpat)
        0:       sample_ready = 1'b1;
        1:       sample_ready = ((c % 2) == 1);
        default: sample_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == extra_at) begin
        start = 1'b1; mode = 2'd1; length = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    start = 1'b0; sample_ready = 1'b1;
    chk("seq_finished", int'(seen), 1);
    nx = xfer_cnt - base;
    nd = done_cnt - d0;
  endtask

  initial begin
    int nx, nd, base, x0, d0, guard;
    reset = 1'b0; start = 1'b0; mode = 2'd0; length = 16'd0; sample_ready = 1'b0;
    #3;
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    // Impulse, length 8, always ready.
    run_seq(2'd1, 8, 0, -1, nx, nd, base);
    chk("imp_xfers", nx, 8);
    chk("imp_done", nd, 1);
    chk("imp_s0", cap[base % 256], 10000);
    for (int i = 1; i < 8; i++) chk("imp_tail", cap[(base + i) % 256], 0);

    // Step, length 4, ready toggling.
    run_seq(2'd2, 4, 1, -1, nx, nd, base);
    chk("step_xfers", nx, 4);
    for (int i = 0; i < 4; i++) chk("step_val", cap[(base + i) % 256], 800);
    chk("step_busy_after", int'(busy), 0);

    // Tone, length 30: literals derived from the square-wave rule.
    run_seq(2'd0, 30, 0, -1, nx, nd, base);
    chk("tone_xfers", nx, 30);
    chk("tone_n0", cap[base % 256], 1200);
    chk("tone_n5", cap[(base + 5) % 256], 1000);
    chk("tone_n12", cap[(base + 12) % 256], 1000);
    chk("tone_n15", cap[(base + 15) % 256], 800);
    chk("tone_n24", cap[(base + 24) % 256], 1200);
    chk("tone_n25", cap[(base + 25) % 256], 1000);

    // Length 0: done only.
    run_seq(2'd2, 0, 0, -1, nx, nd, base);
    chk("len0_xfers", nx, 0);
    chk("len0_done", nd, 1);

    // Step length 10 with a spurious start mid-run.
    run_seq(2'd2, 10, 0, 3, nx, nd, base);
    chk("restart_ignored_xfers", nx, 10);
    chk("restart_ignored_done", nd, 1);

    // Reserved mode, random ready.
    run_seq(2'd3, 3, 2, -1, nx, nd, base);
    chk("rsvd_xfers", nx, 3);
    for (int i = 0; i < 3; i++) chk("rsvd_val", cap[(base + i) % 256], 0);

    // Reset at n=3 of an impulse run.
    x0 = xfer_cnt; d0 = done_cnt;
    @(negedge clk); #1;
    mode = 2'd1; length = 16'd16; start = 1'b1; sample_ready = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    guard = 0;
    while ((xfer_cnt - x0) < 3 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("abort_point", xfer_cnt - x0, 3);
    reset = 1'b0;
    #1;
    chk("abort_valid", int'(sample_valid), 0);
    chk("abort_sample", int'(sample), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_seq(2'd1, 2, 0, -1, nx, nd, base);
    chk("after_abort_xfers", nx, 2);
    chk("after_abort_s0", cap[base % 256], 10000);
    chk("after_abort_s1", cap[(base + 1) % 256], 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
